fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arb_pkg.sv | 21 ++
 rtl/fb_wr_fifo.sv | 65 ++++++
 rtl/fb_arbiter.sv | 129 ++++++++++++
 tb/tb_fb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared defaults and types for the framebuffer arbiter.
package fb_arb_pkg;

  localparam int unsigned AW_DEF            = 14;
  localparam int unsigned DW_DEF            = 8;
  localparam int unsigned FIFO_DEPTH_DEF    = 2;
  localparam bit          WR_BLANK_ONLY_DEF = 1'b0;

  // One buffered host write at default widths.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wr_entry_t;

  // Swap request tracking.
  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Host write buffer: power-of-two circular FIFO with count-based, registered full/empty.
module fb_wr_fifo
  import fb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter type         T     = wr_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointers, occupancy and flags; flags follow the next count so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads win the single RAM port,
// buffered host writes fill the back buffer, swaps commit at vertical begin.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned AW            = AW_DEF,
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter bit          WR_BLANK_ONLY = WR_BLANK_ONLY_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          active,
  input  logic          v_begin,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_done,
  output logic          fb_sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t      push_entry;
  entry_t      head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        wr_eligible;
  logic        commit;
  swap_state_t swap_state;

  assign host_ready  = !fifo_full && !swap_pending;
  assign push        = host_valid && host_ready;
  assign push_entry  = '{addr: host_addr, data: host_data};
  assign wr_eligible = !fifo_empty && (!WR_BLANK_ONLY || !active);
  // Host is blocked while a swap is pending, so an empty FIFO here means the back buffer is complete.
  assign commit      = clk_en && v_begin && swap_pending && fifo_empty;
  assign disp_rdata  = mem_rdata;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (mem_we),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // RAM port mux: display read first, then a host write to the back buffer; idle while in reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {fb_sel, disp_addr};
    mem_wdata = head.data;
    if (!rst_n) begin
      mem_en = 1'b0;
    end else if (disp_req) begin
      mem_en = 1'b1;
    end else if (wr_eligible) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = {~fb_sel, head.addr};
    end
  end

  // Display read return: fixed one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rvalid <= 1'b0;
    end else begin
      disp_rvalid <= disp_req;
    end
  end

  // Swap FSM: latch a request, flip the front buffer at a drained frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_state   <= SW_IDLE;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      fb_sel       <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (swap_state)
        SW_IDLE: begin
          if (swap_req) begin
            swap_state   <= SW_PENDING;
            swap_pending <= 1'b1;
          end
        end
        SW_PENDING: begin
          if (commit) begin
            swap_state   <= SW_IDLE;
            swap_pending <= 1'b0;
            swap_done    <= 1'b1;
            fb_sel       <= ~fb_sel;
          end
        end
        default: begin
          swap_state   <= SW_IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: vector table, hand-written swap/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_fb_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en, active, v_begin;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          host_valid, host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          swap_req, swap_pending, swap_done, fb_sel;
  logic          mem_en, mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fb_arbiter #(
    .AW            (AW),
    .DW            (DW),
    .FIFO_DEPTH    (FD),
    .WR_BLANK_ONLY (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .active       (active),
    .v_begin      (v_begin),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_rvalid  (disp_rvalid),
    .disp_rdata   (disp_rdata),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .fb_sel       (fb_sel),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Synchronous single-port RAM covering both buffers.
  logic [DW-1:0] ram    [1 << (AW + 1)];
  logic [DW-1:0] shadow [1 << (AW + 1)];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          dr;
    logic [AW-1:0] da;
    logic          hv;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          e_rdy;
    logic          e_en;
    logic          e_we;
    logic [AW:0]   e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(logic dr, logic [AW-1:0] da, logic hv, logic [AW-1:0] ha,
                              logic [DW-1:0] hd, logic rdy, logic en, logic we,
                              logic [AW:0] ad, logic [DW-1:0] wd, logic rv, logic [DW-1:0] rd);
    vec_t r;
    r.dr = dr; r.da = da; r.hv = hv; r.ha = ha; r.hd = hd;
    r.e_rdy = rdy; r.e_en = en; r.e_we = we; r.e_addr = ad; r.e_wd = wd;
    r.e_rv = rv; r.e_rd = rd;
    return r;
  endfunction

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  vec_t vecs [15];

  initial begin
    ent_t          mq[$];
    logic          m_sel, m_pend, m_done, m_rv, wr, commit, e_rdy;
    logic [DW-1:0] m_rd;
    logic [AW:0]   e_addr;

    for (int unsigned i = 0; i < (1 << (AW + 1)); i++) ram[i] = '0;
    for (int unsigned i = 0; i < 5; i++) ram[15'h0100 + i] = 8'h60 + 8'(i);
    ram[15'h0123] = 8'h5A;

    // dr  da      hv ha      hd     rdy en we addr      wd     rv rd
    vecs[0]  = mk(0, 14'h0,   0, 14'h0,  8'h00, 1, 0, 0, 15'h0,    8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 14'h0,   1, 14'h10, 8'hAB, 1, 0, 0, 15'h0,    8'h00, 0, 8'h00);
    vecs[2]  = mk(0, 14'h0,   1, 14'h11, 8'hCD, 1, 1, 1, 15'h4010, 8'hAB, 0, 8'h00);
    vecs[3]  = mk(0, 14'h0,   0, 14'h0,  8'h00, 1, 1, 1, 15'h4011, 8'hCD, 0, 8'h00);
    vecs[4]  = mk(0, 14'h0,   0, 14'h0,  8'h00, 1, 0, 0, 15'h0,    8'h00, 0, 8'h00);
    vecs[5]  = mk(1, 14'h100, 1, 14'h20, 8'h11, 1, 1, 0, 15'h0100, 8'h00, 0, 8'h00);
    vecs[6]  = mk(1, 14'h101, 1, 14'h21, 8'h22, 1, 1, 0, 15'h0101, 8'h00, 1, 8'h60);
    vecs[7]  = mk(1, 14'h102, 1, 14'h22, 8'h33, 0, 1, 0, 15'h0102, 8'h00, 1, 8'h61);
    vecs[8]  = mk(1, 14'h103, 0, 14'h0,  8'h00, 0, 1, 0, 15'h0103, 8'h00, 1, 8'h62);
    vecs[9]  = mk(1, 14'h104, 0, 14'h0,  8'h00, 0, 1, 0, 15'h0104, 8'h00, 1, 8'h63);
    vecs[10] = mk(0, 14'h0,   0, 14'h0,  8'h00, 0, 1, 1, 15'h4020, 8'h11, 1, 8'h64);
    vecs[11] = mk(0, 14'h0,   0, 14'h0,  8'h00, 1, 1, 1, 15'h4021, 8'h22, 0, 8'h00);
    vecs[12] = mk(0, 14'h0,   0, 14'h0,  8'h00, 1, 0, 0, 15'h0,    8'h00, 0, 8'h00);
    vecs[13] = mk(1, 14'h123, 0, 14'h0,  8'h00, 1, 1, 0, 15'h0123, 8'h00, 0, 8'h00);
    vecs[14] = mk(0, 14'h0,   0, 14'h0,  8'h00, 1, 0, 0, 15'h0,    8'h00, 1, 8'h5A);

    rst_n = 1'b0; clk_en = 0; active = 0; v_begin = 0; disp_req = 0; disp_addr = '0;
    host_valid = 0; host_addr = '0; host_data = '0; swap_req = 0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_fb_sel", fb_sel, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_done", swap_done, 0);
    chk("rst_rvalid", disp_rvalid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table: write ordering, display priority, read latency.
    for (int i = 0; i < 15; i++) begin
      disp_req = vecs[i].dr; disp_addr = vecs[i].da;
      host_valid = vecs[i].hv; host_addr = vecs[i].ha; host_data = vecs[i].hd;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), host_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d_en", i), mem_en, vecs[i].e_en);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
      if (vecs[i].e_en) chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d_rvalid", i), disp_rvalid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("v%0d_rdata", i), disp_rdata, vecs[i].e_rd);
      nxt();
    end
    disp_req = 0; host_valid = 0;

    // Swap with empty FIFO; v_begin without clk_en is ignored.
    swap_req = 1;
    @(negedge clk); chk("s1_pend0", swap_pending, 0); chk("s1_ready0", host_ready, 1); nxt();
    swap_req = 0;
    @(negedge clk); chk("s1_pend1", swap_pending, 1); chk("s1_ready1", host_ready, 0); nxt();
    v_begin = 1; clk_en = 0;
    @(negedge clk); nxt();
    @(negedge clk); chk("s1_noce_pend", swap_pending, 1); chk("s1_noce_sel", fb_sel, 0);
    clk_en = 1;
    nxt();
    v_begin = 0; clk_en = 0;
    @(negedge clk); chk("s1_sel", fb_sel, 1); chk("s1_done", swap_done, 1);
    chk("s1_pend_clr", swap_pending, 0); chk("s1_ready_back", host_ready, 1); nxt();
    @(negedge clk); chk("s1_done_pulse", swap_done, 0); chk("s1_sel_hold", fb_sel, 1); nxt();

    // Request coincident with v_begin must wait for the next frame.
    swap_req = 1; v_begin = 1; clk_en = 1;
    @(negedge clk); nxt();
    swap_req = 0; v_begin = 0; clk_en = 0;
    @(negedge clk); chk("s2_sel_hold", fb_sel, 1); chk("s2_pend", swap_pending, 1);
    chk("s2_nodone", swap_done, 0); nxt();
    v_begin = 1; clk_en = 1;
    @(negedge clk); nxt();
    v_begin = 0; clk_en = 0;
    @(negedge clk); chk("s2_sel", fb_sel, 0); chk("s2_done", swap_done, 1); nxt();

    // Write stalled by active display defers the swap until drained.
    active = 1; host_valid = 1; host_addr = 14'h30; host_data = 8'h44;
    @(negedge clk); chk("s3_ready", host_ready, 1); nxt();
    host_valid = 0;
    @(negedge clk); chk("s3_stall", mem_en, 0); nxt();
    swap_req = 1;
    @(negedge clk); nxt();
    swap_req = 0; v_begin = 1; clk_en = 1;
    @(negedge clk); chk("s3_pend", swap_pending, 1); nxt();
    v_begin = 0; clk_en = 0;
    @(negedge clk); chk("s3_defer_sel", fb_sel, 0); chk("s3_defer_done", swap_done, 0);
    chk("s3_defer_pend", swap_pending, 1); nxt();
    active = 0;
    @(negedge clk); chk("s3_wr_we", mem_we, 1); chk("s3_wr_addr", mem_addr, 15'h4030);
    chk("s3_wr_data", mem_wdata, 8'h44); nxt();
    @(negedge clk); chk("s3_idle", mem_en, 0); nxt();
    v_begin = 1; clk_en = 1;
    @(negedge clk); nxt();
    v_begin = 0; clk_en = 0;
    @(negedge clk); chk("s3_sel", fb_sel, 1); chk("s3_done", swap_done, 1); nxt();

    // Reset with buffered writes and a pending swap.
    active = 1; host_valid = 1; host_addr = 14'h40; host_data = 8'h55;
    @(negedge clk); nxt();
    host_addr = 14'h41; host_data = 8'h66;
    @(negedge clk); chk("s4_ready2", host_ready, 1); nxt();
    host_valid = 0; swap_req = 1;
    @(negedge clk); chk("s4_full", host_ready, 0); nxt();
    swap_req = 0;
    @(negedge clk); chk("s4_pend", swap_pending, 1);
    rst_n = 0; active = 0;
    #1;
    chk("s4_rst_en", mem_en, 0); chk("s4_rst_sel", fb_sel, 0);
    chk("s4_rst_pend", swap_pending, 0); chk("s4_rst_ready", host_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("s4_post%0d_en", i), mem_en, 0);
      chk($sformatf("s4_post%0d_ready", i), host_ready, 1);
      chk($sformatf("s4_post%0d_sel", i), fb_sel, 0);
      nxt();
    end

    // Randomized traffic against a queue model built from the arbitration rules.
    for (int unsigned i = 0; i < (1 << (AW + 1)); i++) shadow[i] = ram[i];
    m_sel = 0; m_pend = 0; m_done = 0; m_rv = 0; m_rd = '0;
    for (int c = 0; c < 3000; c++) begin
      disp_req   = ($urandom_range(0, 99) < 40);
      disp_addr  = AW'($urandom);
      active     = ($urandom_range(0, 99) < 50);
      host_valid = ($urandom_range(0, 99) < 50);
      host_addr  = AW'($urandom);
      host_data  = DW'($urandom);
      swap_req   = ($urandom_range(0, 99) < 5);
      v_begin    = ($urandom_range(0, 99) < 8);
      clk_en     = ($urandom_range(0, 99) < 50);
      @(negedge clk);
      e_rdy = (mq.size() < FD) && !m_pend;
      wr    = !disp_req && (mq.size() > 0) && !active;
      chk("r_ready", host_ready, e_rdy);
      chk("r_en", mem_en, disp_req || wr);
      chk("r_we", mem_we, wr);
      if (disp_req) begin
        e_addr = {m_sel, disp_addr};
        chk("r_raddr", mem_addr, e_addr);
      end else if (wr) begin
        e_addr = {~m_sel, mq[0].a};
        chk("r_waddr", mem_addr, e_addr);
        chk("r_wdata", mem_wdata, mq[0].d);
      end
      chk("r_rvalid", disp_rvalid, m_rv);
      if (m_rv) chk("r_rdata", disp_rdata, m_rd);
      chk("r_pend", swap_pending, m_pend);
      chk("r_done", swap_done, m_done);
      chk("r_sel", fb_sel, m_sel);
      // Advance the model across the clock edge.
      commit = clk_en && v_begin && m_pend && (mq.size() == 0);
      m_rv = disp_req;
      if (disp_req) m_rd = shadow[{m_sel, disp_addr}];
      if (wr) begin
        shadow[{~m_sel, mq[0].a}] = mq[0].d;
        void'(mq.pop_front());
      end
      if (host_valid && e_rdy) mq.push_back('{a: host_addr, d: host_data});
      m_done = commit;
      if (commit) begin
        m_sel  = ~m_sel;
        m_pend = 0;
      end else if (swap_req && !m_pend) begin
        m_pend = 1;
      end
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
